// File: rtl/int_sched_ctrl_if.sv
// rtl/int_sched_ctrl_if.sv - signal bundle between the interrupt scheduler and CPU exception control
interface int_sched_ctrl_if;
  logic [5:0] HWInt;
  logic [5:0] IM;
  logic       IE;
  logic       ExlSet;
  logic       EretReq;
  logic       ClrPend;
  logic [2:0] ClrIdx;
  logic       IntReq;
  logic [2:0] IntCode;
  logic [5:0] Pending;
  logic       Exl;

  modport master (
    output HWInt, IM, IE, ExlSet, EretReq, ClrPend, ClrIdx,
    input  IntReq, IntCode, Pending, Exl
  );

  modport slave (
    input  HWInt, IM, IE, ExlSet, EretReq, ClrPend, ClrIdx,
    output IntReq, IntCode, Pending, Exl
  );
endinterface

// File: rtl/int_sched_ctrl.sv
// rtl/int_sched_ctrl.sv - interrupt line latching, masking, priority pick and handler/lock-out tracking
module int_sched_ctrl #(
  parameter int         NUM_IRQ   = 6,
  parameter logic [5:0] EDGE_MASK = 6'b000000,
  parameter int         LOCKOUT   = 2
) (
  input logic             clk,
  input logic             reset,
  int_sched_ctrl_if.slave bus
);
  localparam int CW = (LOCKOUT > 2) ? $clog2(LOCKOUT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (LOCKOUT > 0) ? CW'(LOCKOUT - 1) : '0;

  typedef enum logic [1:0] {ST_RUN, ST_HANDLER, ST_DRAIN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               exl;
  logic [NUM_IRQ-1:0] samp;
  logic [NUM_IRQ-1:0] samp_d;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] pend_next;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr_hit;
  logic [NUM_IRQ-1:0] eff;
  logic [2:0]         code;

  assign rise = samp & ~samp_d;
  assign eff  = pend & bus.IM;

  // Indices 6 and 7 never match a line, so out-of-range clears fall away naturally.
  always_comb begin
    clr_hit = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_hit[i] = bus.ClrPend && (bus.ClrIdx == 3'(i));
    end
  end

  // Sticky edge bits: a new rising edge overrides a clear in the same cycle.
  assign pend_next = (EDGE_MASK & ((pend & ~clr_hit) | rise)) | (~EDGE_MASK & samp);

  always_comb begin
    code = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eff[i]) code = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp   <= '0;
      samp_d <= '0;
      pend   <= '0;
      state  <= ST_RUN;
      cnt    <= '0;
      exl    <= 1'b0;
    end else begin
      samp   <= bus.HWInt;
      samp_d <= samp;
      pend   <= pend_next;
      case (state)
        ST_RUN: begin
          if (bus.ExlSet) begin
            state <= ST_HANDLER;
            exl   <= 1'b1;
          end
        end
        ST_HANDLER: begin
          if (!bus.ExlSet && bus.EretReq) begin
            exl <= 1'b0;
            if (LOCKOUT == 0) begin
              state <= ST_RUN;
            end else begin
              state <= ST_DRAIN;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.ExlSet) begin
            state <= ST_HANDLER;
            exl   <= 1'b1;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
          exl   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IntReq  = bus.IE & (state == ST_RUN) & (|eff);
  assign bus.IntCode = code;
  assign bus.Pending = pend;
  assign bus.Exl     = exl;
endmodule

// File: tb/tb_int_sched_ctrl.sv
// tb/tb_int_sched_ctrl.sv - three lock-out builds on shared stimulus, checked every cycle against a history/counter model
module tb_int_sched_ctrl;
  localparam logic [5:0] EM = 6'b001101;
  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] hw;
  logic [5:0] im;
  logic       ie;
  logic       exl_set;
  logic       eret;
  logic       clr;
  logic [2:0] clr_idx;

  int n_checks = 0;
  int n_errors = 0;

  int_sched_ctrl_if bus0 ();
  int_sched_ctrl_if bus1 ();
  int_sched_ctrl_if bus2 ();

  int_sched_ctrl #(.NUM_IRQ(6), .EDGE_MASK(EM), .LOCKOUT(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  int_sched_ctrl #(.NUM_IRQ(6), .EDGE_MASK(EM), .LOCKOUT(3)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  int_sched_ctrl #(.NUM_IRQ(6), .EDGE_MASK(EM), .LOCKOUT(0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus0.HWInt = hw;      assign bus1.HWInt = hw;      assign bus2.HWInt = hw;
  assign bus0.IM = im;         assign bus1.IM = im;         assign bus2.IM = im;
  assign bus0.IE = ie;         assign bus1.IE = ie;         assign bus2.IE = ie;
  assign bus0.ExlSet = exl_set; assign bus1.ExlSet = exl_set; assign bus2.ExlSet = exl_set;
  assign bus0.EretReq = eret;  assign bus1.EretReq = eret;  assign bus2.EretReq = eret;
  assign bus0.ClrPend = clr;   assign bus1.ClrPend = clr;   assign bus2.ClrPend = clr;
  assign bus0.ClrIdx = clr_idx; assign bus1.ClrIdx = clr_idx; assign bus2.ClrIdx = clr_idx;

  always #5 clk = ~clk;

  // Model: hist[0] is the value applied at the latest edge, hist[1] one edge earlier, etc.
  logic [5:0] hist[$];
  logic [5:0] m_pend;
  int         m_hand[NI];
  int         m_lock[NI];

  function automatic int lockout_of(int k);
    case (k)
      0: return 2;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] lowest_set(logic [5:0] v);
    for (int i = 0; i < 6; i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic get_obs(int k, output logic req, output logic [2:0] code,
                         output logic [5:0] pend, output logic exl);
    case (k)
      0: begin req = bus0.IntReq; code = bus0.IntCode; pend = bus0.Pending; exl = bus0.Exl; end
      1: begin req = bus1.IntReq; code = bus1.IntCode; pend = bus1.Pending; exl = bus1.Exl; end
      default: begin req = bus2.IntReq; code = bus2.IntCode; pend = bus2.Pending; exl = bus2.Exl; end
    endcase
  endtask

  task automatic model_edge();
    logic [5:0] np;
    if (reset) begin
      hist = {6'h00, 6'h00, 6'h00};
      m_pend = '0;
      for (int k = 0; k < NI; k++) begin
        m_hand[k] = 0;
        m_lock[k] = 0;
      end
    end else begin
      hist.push_front(hw);
      hist.delete(3);
      for (int i = 0; i < 6; i++) begin
        if (EM[i])
          np[i] = (hist[1][i] & ~hist[2][i]) | (m_pend[i] & ~(clr && (int'(clr_idx) == i)));
        else
          np[i] = hist[1][i];
      end
      m_pend = np;
      for (int k = 0; k < NI; k++) begin
        if (exl_set) begin
          m_hand[k] = 1;
          m_lock[k] = 0;
        end else if (m_hand[k] != 0 && eret) begin
          m_hand[k] = 0;
          m_lock[k] = lockout_of(k);
        end else if (m_lock[k] > 0) begin
          m_lock[k] = m_lock[k] - 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic       oreq;
    logic       oexl;
    logic [2:0] ocode;
    logic [5:0] opend;
    logic       ereq;
    for (int k = 0; k < NI; k++) begin
      get_obs(k, oreq, ocode, opend, oexl);
      ereq = ie && (m_hand[k] == 0) && (m_lock[k] == 0) && ((m_pend & im) != 6'h00);
      check($sformatf("pending%0d", k), 32'(opend), 32'(m_pend));
      check($sformatf("exl%0d", k), 32'(oexl), 32'(m_hand[k] != 0));
      check($sformatf("intreq%0d", k), 32'(oreq), 32'(ereq));
      check($sformatf("intcode%0d", k), 32'(ocode), 32'(lowest_set(m_pend & im)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    hist = {6'h00, 6'h00, 6'h00};
    m_pend = '0;
    reset = 1'b1; hw = '0; im = 6'h3f; ie = 1'b1;
    exl_set = 1'b0; eret = 1'b0; clr = 1'b0; clr_idx = '0;
    steps(2);
    reset = 1'b0;
    check("rst_pending", 32'(bus0.Pending), 32'h0);
    check("rst_exl", 32'(bus0.Exl), 32'h0);
    check("rst_intreq", 32'(bus0.IntReq), 32'h0);
    check("rst_intcode", 32'(bus0.IntCode), 32'h0);

    // Single-cycle pulse on edge line 2 sticks until cleared.
    hw = 6'b000100; step();
    hw = 6'b000000; step();
    check("edge_pend", 32'(bus0.Pending), 32'h04);
    check("edge_req", 32'(bus0.IntReq), 32'h1);
    check("edge_code", 32'(bus0.IntCode), 32'h2);
    steps(3);
    check("edge_hold", 32'(bus0.Pending), 32'h04);
    clr = 1'b1; clr_idx = 3'd2; step();
    clr = 1'b0;
    check("edge_clr_pend", 32'(bus0.Pending), 32'h0);
    check("edge_clr_req", 32'(bus0.IntReq), 32'h0);

    // Priority and masking on level lines 1 and 4.
    hw = 6'b010010; steps(2);
    im = 6'b111101; #1;
    check("prio_masked", 32'(bus0.IntCode), 32'h4);
    im = 6'h3f; #1;
    check("prio_open", 32'(bus0.IntCode), 32'h1);
    ie = 1'b0; #1;
    check("ie_off_req", 32'(bus0.IntReq), 32'h0);
    check("ie_off_pend", 32'(bus0.Pending), 32'h12);
    step();

    // Handler entry, eret and lock-out window with line 4 held.
    ie = 1'b1; hw = 6'b010000; steps(2);
    check("hdl_pre_req", 32'(bus0.IntReq), 32'h1);
    exl_set = 1'b1; step();
    exl_set = 1'b0;
    check("hdl_exl", 32'(bus0.Exl), 32'h1);
    check("hdl_req", 32'(bus0.IntReq), 32'h0);
    steps(4);
    eret = 1'b1; step();
    eret = 1'b0;
    check("eret_exl", 32'(bus0.Exl), 32'h0);
    check("eret_req_t6", 32'(bus0.IntReq), 32'h0);
    check("lk0_req_next", 32'(bus2.IntReq), 32'h1);
    step();
    check("eret_req_t7", 32'(bus0.IntReq), 32'h0);
    step();
    check("eret_req_t8", 32'(bus0.IntReq), 32'h1);
    check("lk3_req_t8", 32'(bus1.IntReq), 32'h0);
    step();
    check("lk3_req_t9", 32'(bus1.IntReq), 32'h1);

    // ExlSet and EretReq together while in handler.
    exl_set = 1'b1; step();
    exl_set = 1'b0; step();
    exl_set = 1'b1; eret = 1'b1; step();
    exl_set = 1'b0;
    check("both_exl", 32'(bus0.Exl), 32'h1);
    step();
    eret = 1'b0;
    steps(4);

    // Clear racing a fresh rising edge on edge line 0, then plain clear and level-line clear.
    hw = 6'b000001; step();
    hw = 6'b000000; steps(3);
    hw = 6'b000001; step();
    clr = 1'b1; clr_idx = 3'd0; step();
    clr = 1'b0;
    check("race_set_wins", 32'(bus0.Pending[0]), 32'h1);
    hw = 6'b000010; steps(2);
    clr = 1'b1; clr_idx = 3'd0; step();
    check("clr0_alone", 32'(bus0.Pending[0]), 32'h0);
    clr_idx = 3'd1; step();
    clr = 1'b0;
    check("clr_level_noeffect", 32'(bus0.Pending[1]), 32'h1);

    // ExlSet one cycle into the LOCKOUT=3 drain, then a full lock-out.
    hw = 6'b010000; steps(2);
    exl_set = 1'b1; step();
    exl_set = 1'b0; step();
    eret = 1'b1; step();
    eret = 1'b0; exl_set = 1'b1; step();
    exl_set = 1'b0;
    check("drain_abort_exl", 32'(bus1.Exl), 32'h1);
    steps(2);
    eret = 1'b1; step();
    eret = 1'b0;
    check("lk3_d1", 32'(bus1.IntReq), 32'h0);
    step();
    check("lk3_d2", 32'(bus1.IntReq), 32'h0);
    step();
    check("lk3_d3", 32'(bus1.IntReq), 32'h0);
    step();
    check("lk3_run", 32'(bus1.IntReq), 32'h1);

    // Reset while in handler with a sticky bit on edge line 3.
    hw = 6'b001000; step();
    hw = 6'b000000; steps(3);
    exl_set = 1'b1; step();
    exl_set = 1'b0; step();
    check("pre_rst_pend", 32'(bus0.Pending), 32'h08);
    check("pre_rst_exl", 32'(bus0.Exl), 32'h1);
    reset = 1'b1; step();
    reset = 1'b0;
    check("mid_rst_pend", 32'(bus0.Pending), 32'h0);
    check("mid_rst_exl", 32'(bus0.Exl), 32'h0);
    check("mid_rst_req", 32'(bus0.IntReq), 32'h0);
    step();

    // Randomized traffic; ExlSet never reissued in the cycle right after one.
    for (int n = 0; n < 3000; n++) begin
      hw      = 6'($urandom);
      im      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3f;
      ie      = ($urandom_range(0, 7) != 0);
      exl_set = !exl_set && ($urandom_range(0, 9) == 0);
      eret    = ($urandom_range(0, 5) == 0);
      clr     = ($urandom_range(0, 2) == 0);
      clr_idx = 3'($urandom);
      reset   = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; exl_set = 1'b0; eret = 1'b0; clr = 1'b0;
    steps(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
